// File: rtl/segment_display_scanner_pkg.sv
// Shared definitions for the segment display scanner.
//   ANODE_OFF          : level of one inactive (active-low) anode bit
//   DEFAULT_BLANK_CODE : HexDigit code the downstream decoder renders dark
//   MAX_DIGITS         : widest display the helper function handles
//   highest_nonzero()  : index of the most significant nonzero hex digit
package segment_display_scanner_pkg;

  localparam logic       ANODE_OFF          = 1'b1;
  localparam logic [3:0] DEFAULT_BLANK_CODE = 4'hF;
  localparam int         MAX_DIGITS         = 8;

  // Returns the index of the highest nonzero digit among the lowest `digits`
  // digits of `value`. An all-zero value returns 0, so digit 0 is always
  // treated as significant.
  function automatic logic [2:0] highest_nonzero(
    input logic [4*MAX_DIGITS-1:0] value,
    input int                      digits
  );
    logic [2:0] hi;
    hi = '0;
    for (int i = 0; i < MAX_DIGITS; i++) begin
      if (i < digits && value[4*i +: 4] != 4'h0) hi = 3'(i);
    end
    return hi;
  endfunction

endpackage

// File: rtl/segment_display_scanner_scan_prescaler.sv
// Modulo-N counter with a wrap strobe, used to pace display multiplexing.
//   clk   : clock
//   rst   : asynchronous active-high reset, clears the count
//   en    : count enable; when low the count holds and wrap stays low
//   count : current count, 0..N-1
//   wrap  : high during the cycle whose rising edge returns count to 0
module segment_display_scanner_scan_prescaler #(
  parameter int N     = 50000,
  parameter int CNT_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [CNT_W-1:0] count,
  output logic             wrap
);

  assign wrap = en && (count == CNT_W'(N - 1));

  // NOTE: state registers use non-blocking assignment so every flop samples
  // the pre-edge values regardless of the order blocks are evaluated.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (en) begin
      count <= wrap ? '0 : count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/segment_display_scanner.sv
// Time-multiplexed scan controller for a common-anode 7-segment display.
// Drives the hex-to-segment decoder's HexDigit input and the digit anodes.
//   Clk, Reset   : clock, asynchronous active-high reset
//   Value        : packed hex digits, digit 0 in Value[3:0] (rightmost)
//   DotMask      : per-digit decimal point enables
//   Load         : capture Value/DotMask; shown from the next frame start
//   BlankLeading : suppress leading zeros (applied live, not deferred)
//   HexDigit     : code for the lit digit (BLANK_CODE when dark)
//   Anodes       : active-low digit enables, at most one low
//   DecimalPoint : active-low decimal point segment
//   FrameStart   : one-cycle pulse on the edge that lights digit 0
//   Pending      : a captured value is waiting for the frame boundary
module segment_display_scanner
  import segment_display_scanner_pkg::*;
#(
  parameter int         DIGITS     = 4,
  parameter int         PRESCALE   = 50000,
  parameter logic [3:0] BLANK_CODE = DEFAULT_BLANK_CODE
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic [4*DIGITS-1:0]   Value,
  input  logic [DIGITS-1:0]     DotMask,
  input  logic                  Load,
  input  logic                  BlankLeading,
  output logic [3:0]            HexDigit,
  output logic [DIGITS-1:0]     Anodes,
  output logic                  DecimalPoint,
  output logic                  FrameStart,
  output logic                  Pending
);

  localparam int IDX_W = $clog2(DIGITS);
  localparam int CNT_W = $clog2(PRESCALE);

  logic                running;
  logic [IDX_W-1:0]    idx;
  logic [CNT_W-1:0]    count;
  logic                wrap;
  logic                frame_wrap;
  logic [4*DIGITS-1:0] shadow_value, disp_value;
  logic [DIGITS-1:0]   shadow_dot, disp_dot;

  logic [IDX_W-1:0]    top_digit;
  logic                dark;
  logic [3:0]          next_hex;
  logic [DIGITS-1:0]   next_anodes;
  logic                next_dp;
  logic                next_fs;

  // The scan is held for the first cycle after reset release so that digit 0
  // lights on the second edge and still receives a full PRESCALE slot.
  segment_display_scanner_scan_prescaler #(
    .N     (PRESCALE),
    .CNT_W (CNT_W)
  ) u_prescaler (
    .clk   (Clk),
    .rst   (Reset),
    .en    (running),
    .count (count),
    .wrap  (wrap)
  );

  assign frame_wrap = wrap && (idx == IDX_W'(DIGITS - 1));

  // NOTE: shadow and display are ordinary flops rather than a memory array,
  // so they take the asynchronous reset along with the rest of the state.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      running      <= 1'b0;
      idx          <= '0;
      shadow_value <= '0;
      shadow_dot   <= '0;
      disp_value   <= '0;
      disp_dot     <= '0;
      Pending      <= 1'b0;
    end else begin
      running <= 1'b1;
      if (wrap) idx <= frame_wrap ? '0 : idx + IDX_W'(1);

      if (frame_wrap && Load) begin
        // A load landing on the boundary goes straight to the display.
        disp_value <= Value;
        disp_dot   <= DotMask;
        Pending    <= 1'b0;
      end else if (frame_wrap && Pending) begin
        disp_value <= shadow_value;
        disp_dot   <= shadow_dot;
        Pending    <= 1'b0;
      end else if (Load) begin
        shadow_value <= Value;
        shadow_dot   <= DotMask;
        Pending      <= 1'b1;
      end
    end
  end

  // Outputs for the digit currently selected by idx; they appear one edge
  // after idx changes.
  // NOTE: every signal assigned in this block gets a default first so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    next_hex    = BLANK_CODE;
    next_anodes = {DIGITS{ANODE_OFF}};
    next_dp     = 1'b1;
    next_fs     = 1'b0;
    top_digit   = IDX_W'(highest_nonzero((4*MAX_DIGITS)'(disp_value), DIGITS));
    // idx above the highest nonzero digit implies idx > 0, so digit 0 is
    // never dark.
    dark        = BlankLeading && (idx > top_digit);
    if (running) begin
      next_hex = dark ? BLANK_CODE : disp_value[4*idx +: 4];
      // A dark digit with its decimal point set keeps its anode on.
      if (!dark || disp_dot[idx]) next_anodes = ~(DIGITS'(1) << idx);
      next_dp  = ~disp_dot[idx];
      next_fs  = (idx == '0) && (count == '0);
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      HexDigit     <= BLANK_CODE;
      Anodes       <= {DIGITS{ANODE_OFF}};
      DecimalPoint <= 1'b1;
      FrameStart   <= 1'b0;
    end else begin
      HexDigit     <= next_hex;
      Anodes       <= next_anodes;
      DecimalPoint <= next_dp;
      FrameStart   <= next_fs;
    end
  end

endmodule

// File: tb/tb_segment_display_scanner.sv
// Self-checking bench for segment_display_scanner with DIGITS = 4 and
// PRESCALE = 4. The reference model derives the lit digit and the frame
// boundaries from the number of clock edges since reset release, and
// applies the load/commit rules to plain variables.
module tb_segment_display_scanner;

  localparam int DIGITS   = 4;
  localparam int PRESCALE = 4;
  localparam int FRAME    = DIGITS * PRESCALE;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic [15:0] Value = '0;
  logic [3:0]  DotMask = '0;
  logic        Load = 1'b0;
  logic        BlankLeading = 1'b0;
  logic [3:0]  HexDigit;
  logic [3:0]  Anodes;
  logic        DecimalPoint;
  logic        FrameStart;
  logic        Pending;

  segment_display_scanner #(
    .DIGITS     (DIGITS),
    .PRESCALE   (PRESCALE),
    .BLANK_CODE (4'hF)
  ) dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .Value        (Value),
    .DotMask      (DotMask),
    .Load         (Load),
    .BlankLeading (BlankLeading),
    .HexDigit     (HexDigit),
    .Anodes       (Anodes),
    .DecimalPoint (DecimalPoint),
    .FrameStart   (FrameStart),
    .Pending      (Pending)
  );

  always #5 Clk = ~Clk;

  int n_compared   = 0;
  int n_mismatched = 0;
  int n_edge       = 0;   // rising edges since reset release

  // Reference model state
  logic [15:0] m_disp, m_shadow;
  logic [3:0]  m_disp_dot, m_shadow_dot;
  logic        m_pend;
  // Expected outputs after the current edge
  logic [3:0]  e_hex, e_an;
  logic        e_dp, e_fs;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %0h, expected %0h (edge %0d)", tag, got, exp, n_edge);
    end
  endtask

  task automatic model_reset();
    n_edge       = 0;
    m_disp       = '0;
    m_shadow     = '0;
    m_disp_dot   = '0;
    m_shadow_dot = '0;
    m_pend       = 1'b0;
  endtask

  // Outputs seen after edge n_edge, from the display contents before it.
  task automatic model_outputs();
    int d;
    logic dark;
    e_hex = 4'hF;
    e_an  = 4'hF;
    e_dp  = 1'b1;
    e_fs  = 1'b0;
    if (n_edge >= 2) begin
      d    = ((n_edge - 2) / PRESCALE) % DIGITS;
      dark = 1'b0;
      if (BlankLeading && d > 0) begin
        dark = 1'b1;
        for (int j = d; j < DIGITS; j++)
          if (m_disp[4*j +: 4] != 4'h0) dark = 1'b0;
      end
      e_hex = dark ? 4'hF : m_disp[4*d +: 4];
      e_an  = (dark && !m_disp_dot[d]) ? 4'hF : ~(4'b0001 << d);
      e_dp  = !m_disp_dot[d];
      e_fs  = ((n_edge - 2) % FRAME) == 0;
    end
  endtask

  // Load/commit rules; the edge that moves the scan from the last digit back
  // to digit 0 is every FRAME-th edge starting at edge FRAME+1.
  task automatic model_update();
    if (n_edge > 1 && ((n_edge - 1) % FRAME) == 0) begin
      if (Load) begin
        m_disp     = Value;
        m_disp_dot = DotMask;
        m_pend     = 1'b0;
      end else if (m_pend) begin
        m_disp     = m_shadow;
        m_disp_dot = m_shadow_dot;
        m_pend     = 1'b0;
      end
    end else if (Load) begin
      m_shadow     = Value;
      m_shadow_dot = DotMask;
      m_pend       = 1'b1;
    end
  endtask

  task automatic cycle();
    @(posedge Clk);
    n_edge++;
    model_outputs();
    model_update();
    #1;
    check("anodes",        32'(Anodes),       32'(e_an));
    check("hex_digit",     32'(HexDigit),     32'(e_hex));
    check("decimal_point", 32'(DecimalPoint), 32'(e_dp));
    check("frame_start",   32'(FrameStart),   32'(e_fs));
    check("pending",       32'(Pending),      32'(m_pend));
  endtask

  task automatic run(input int k);
    for (int i = 0; i < k; i++) cycle();
  endtask

  // Run until n_edge % FRAME == m; the next cycle() is edge with phase m+1.
  task automatic advance_to(input int m);
    cycle();
    while ((n_edge % FRAME) != m) cycle();
  endtask

  task automatic load(input logic [15:0] v, input logic [3:0] dots);
    Value   = v;
    DotMask = dots;
    Load    = 1'b1;
    cycle();
    Load    = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_anodes"},    32'(Anodes),       32'hF);
    check({tag, "_hex_digit"}, 32'(HexDigit),     32'hF);
    check({tag, "_dp"},        32'(DecimalPoint), 32'h1);
    check({tag, "_fs"},        32'(FrameStart),   32'h0);
    check({tag, "_pending"},   32'(Pending),      32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    // Reset held across a clock edge
    #12;
    check_reset_state("in_reset");
    @(negedge Clk);
    Reset = 1'b0;
    model_reset();

    // Free-running scan of an all-zero display
    run(2 + 3*FRAME);

    // Load mid-frame while digit 1 is lit
    advance_to(7);
    load(16'h1A3F, 4'b0000);
    run(2*FRAME);

    // Two loads in one frame: last one wins
    advance_to(3);
    load(16'h1111, 4'b0000);
    advance_to(10);
    load(16'h2222, 4'b0000);
    run(2*FRAME);

    // Load exactly on the frame-boundary edge bypasses to the display
    advance_to(0);
    load(16'h00C5, 4'b0000);
    run(2*FRAME);

    // Leading-zero blanking
    BlankLeading = 1'b1;
    load(16'h0005, 4'b0000);
    run(2*FRAME);
    load(16'h0000, 4'b0000);
    run(2*FRAME);
    // Decimal point on a blanked digit
    load(16'h0005, 4'b0100);
    run(2*FRAME);

    // Randomized loads, dots and blanking
    for (int i = 0; i < 500; i++) begin
      Load    = ($urandom_range(0, 5) == 0);
      Value   = 16'($urandom) >> (4*$urandom_range(0, 4));
      DotMask = 4'($urandom);
      if ($urandom_range(0, 15) == 0) BlankLeading = ~BlankLeading;
      cycle();
    end
    Load = 1'b0;
    BlankLeading = 1'b0;

    // Asynchronous reset mid-slot with a value pending
    advance_to(8);
    load(16'h7777, 4'b1111);
    #3;
    Reset = 1'b1;
    #1;
    check_reset_state("async_reset");
    @(posedge Clk);
    #1;
    check_reset_state("held_reset");
    @(negedge Clk);
    Reset = 1'b0;
    model_reset();
    run(2*FRAME + 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
